// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter family.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   // Width of the per-grant beat counter; bounds the legal maximum burst length.
   localparam int unsigned BURST_CNT_W = 32'd8;

   // Bits needed to hold a requester index; never narrower than one bit.
   function automatic int unsigned grant_id_width(input int unsigned num_req);
      if (num_req <= 32'd2) begin
         return 32'd1;
      end else begin
         return $clog2(num_req);
      end
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request bit at or after a start index,
// wrapping modulo the requester count.
module rr_priority_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned p_NUM_REQ = 4,
   parameter int unsigned p_IDX_W   = grant_id_width(p_NUM_REQ)
) (
   input  logic [p_NUM_REQ-1:0] i_req,
   input  logic [p_IDX_W-1:0]   i_start,
   output logic                 o_found,
   output logic [p_IDX_W-1:0]   o_idx
);

   int                 sum_s;
   logic [p_IDX_W-1:0] cand_s;

   assign o_found = |i_req;

   // Walk offsets from farthest to nearest so the nearest set bit after i_start wins.
   always_comb begin
      o_idx  = '0;
      sum_s  = 32'sd0;
      cand_s = '0;
      for (int ofs = int'(p_NUM_REQ) - 32'sd1; ofs >= 32'sd0; ofs--) begin
         sum_s = int'(i_start) + ofs;
         if (sum_s >= int'(p_NUM_REQ)) begin
            sum_s = sum_s - int'(p_NUM_REQ);
         end else begin
            sum_s = sum_s;
         end
         cand_s = p_IDX_W'(sum_s);
         if (i_req[cand_s]) begin
            o_idx = cand_s;
         end else begin
            o_idx = o_idx;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between several valid/ready/last
// producers. One producer owns the port per grant, for up to p_MAX_BURST beats or
// until its last beat; a stalled producer gives the port up immediately.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned p_NUM_REQ   = 4,
   parameter int unsigned p_WIDTH     = 8,
   parameter int unsigned p_MAX_BURST = 4
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic [p_NUM_REQ-1:0]                 i_req_valid,
   input  logic [p_NUM_REQ*p_WIDTH-1:0]         i_req_data,
   input  logic [p_NUM_REQ-1:0]                 i_req_last,
   output logic [p_NUM_REQ-1:0]                 o_req_ready,
   output logic                                 o_fifo_wr_en,
   output logic [p_WIDTH-1:0]                   o_fifo_wr_data,
   input  logic                                 i_fifo_full,
   output logic [grant_id_width(p_NUM_REQ)-1:0] o_grant_id,
   output logic                                 o_busy
);

   localparam int unsigned             GID_W   = grant_id_width(p_NUM_REQ);
   localparam logic [GID_W-1:0]        LAST_ID = GID_W'(p_NUM_REQ - 32'd1);
   localparam logic [BURST_CNT_W-1:0]  MAX_CNT = BURST_CNT_W'(p_MAX_BURST);

   arb_state_e               state_r, state_nxt_s;
   logic [GID_W-1:0]         grant_r, grant_nxt_s;
   logic [GID_W-1:0]         ptr_r, ptr_nxt_s;
   logic [BURST_CNT_W-1:0]   cnt_r, cnt_nxt_s, cnt_inc_s;

   logic                     pick_found_s;
   logic [GID_W-1:0]         pick_idx_s;

   logic                     g_valid_s;
   logic                     g_last_s;
   logic [p_WIDTH-1:0]       g_data_s;

   logic [p_NUM_REQ-1:0]     ready_s;
   logic                     wr_en_s;
   logic [p_WIDTH-1:0]       wr_data_s;

   rr_priority_pick #(
      .p_NUM_REQ (p_NUM_REQ),
      .p_IDX_W   (GID_W)
   ) u_pick (
      .i_req   (i_req_valid),
      .i_start (ptr_r),
      .o_found (pick_found_s),
      .o_idx   (pick_idx_s)
   );

   assign g_valid_s = i_req_valid[grant_r];
   assign g_last_s  = i_req_last[grant_r];
   assign g_data_s  = i_req_data[32'(grant_r) * p_WIDTH +: p_WIDTH];
   assign cnt_inc_s = cnt_r + BURST_CNT_W'(1);

   // Next-state, handshake and write-port decode; reset forces the port quiet.
   always_comb begin
      state_nxt_s = state_r;
      grant_nxt_s = grant_r;
      ptr_nxt_s   = ptr_r;
      cnt_nxt_s   = cnt_r;
      ready_s     = '0;
      wr_en_s     = 1'b0;
      wr_data_s   = '0;
      if (!i_rst_n) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_found_s) begin
                  grant_nxt_s = pick_idx_s;
                  cnt_nxt_s   = '0;
                  state_nxt_s = ST_BURST;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_BURST: begin
               wr_data_s        = g_data_s;
               ready_s[grant_r] = !i_fifo_full;
               if (!g_valid_s) begin
                  // Producer stalled: hand the port on without writing.
                  state_nxt_s = ST_IDLE;
                  ptr_nxt_s   = (grant_r == LAST_ID) ? '0 : grant_r + GID_W'(1);
               end else if (!i_fifo_full) begin
                  wr_en_s   = 1'b1;
                  cnt_nxt_s = cnt_inc_s;
                  if (g_last_s || (cnt_inc_s == MAX_CNT)) begin
                     state_nxt_s = ST_IDLE;
                     ptr_nxt_s   = (grant_r == LAST_ID) ? '0 : grant_r + GID_W'(1);
                  end else begin
                     state_nxt_s = ST_BURST;
                  end
               end else begin
                  // FIFO full: keep the grant and wait.
                  state_nxt_s = ST_BURST;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, grant, round-robin pointer and beat counter registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         grant_r <= '0;
         ptr_r   <= '0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         grant_r <= grant_nxt_s;
         ptr_r   <= ptr_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   assign o_req_ready    = ready_s;
   assign o_fifo_wr_en   = wr_en_s;
   assign o_fifo_wr_data = wr_data_s;
   assign o_grant_id     = grant_r;
   assign o_busy         = (state_r == ST_BURST);

endmodule
